// File: rtl/dpram_reader_pkg.sv
// Shared types and defaults for the dual-port RAM burst reader.
package dpram_reader_pkg;

  localparam int unsigned DefWidth   = 8;
  localparam int unsigned DefAddress = 6;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

endpackage

// File: rtl/reader_skid_fifo.sv
// Small synchronous FIFO carrying {last, data}; it absorbs RAM read latency and
// downstream stalls.
module reader_skid_fifo #(
  parameter int unsigned Depth = 3,
  parameter int unsigned Width = 9,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic [CntW-1:0]  count_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_en, pop_en;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    pop_en   = pop_i && (count_q != '0);
    push_en  = push_i && ((count_q != CntW'(Depth)) || pop_en);
    wr_ptr_d = push_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CntW'(push_en) - CntW'(pop_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read until count_q says it was written.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/dpram_burst_reader.sv
// Burst read initiator for one RAM port, streaming words out as valid/ready.
// Optional READER_CHECKSUM_EN adds an XOR checksum of the accepted words.
module dpram_burst_reader
  import dpram_reader_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned ADDRESS    = DefAddress,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH = RD_LATENCY + 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDRESS-1:0] base_addr,
  input  logic [ADDRESS:0]   length,
  output logic               busy,
  output logic               done,
  output logic [ADDRESS-1:0] ram_addr,
  output logic               ram_wr_en,
  output logic [WIDTH-1:0]   ram_data_in,
  input  logic [WIDTH-1:0]   ram_data_out,
  output logic [WIDTH-1:0]   m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last
`ifdef READER_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0]   checksum
`endif
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  state_e             state_q, state_d;
  logic [ADDRESS-1:0] addr_q, addr_d, ram_addr_q, ram_addr_d;
  logic [ADDRESS:0]   remaining_q, remaining_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [RD_LATENCY:0] tag_vld_q, tag_vld_d, tag_last_q, tag_last_d;

  logic               issue, last_issue, pop, credit_ok, fifo_empty;
  logic [WIDTH:0]     fifo_head;
  logic [CntW-1:0]    fifo_count;
  int unsigned        in_flight, occupancy;

  always_comb begin
    pop        = !fifo_empty && m_ready;
    in_flight  = 0;
    for (int unsigned i = 0; i <= RD_LATENCY; i++) in_flight += 32'(tag_vld_q[i]);
    // A word popped this edge frees its slot in time for a new issue.
    occupancy  = 32'(fifo_count) + in_flight - 32'(pop);
    credit_ok  = occupancy < FIFO_DEPTH;
    issue      = (state_q == ISSUE) && credit_ok;
    last_issue = issue && (remaining_q == (ADDRESS + 1)'(1));
    tag_vld_d  = {tag_vld_q[RD_LATENCY-1:0], issue};
    tag_last_d = {tag_last_q[RD_LATENCY-1:0], last_issue};
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ram_addr_d  = ram_addr_q;
    remaining_d = remaining_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d     = ISSUE;
            busy_d      = 1'b1;
            addr_d      = base_addr;
            remaining_d = length;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          ram_addr_d  = addr_q;
          addr_d      = addr_q + ADDRESS'(1);
          remaining_d = remaining_q - (ADDRESS + 1)'(1);
          if (last_issue) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && fifo_head[WIDTH]) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      ram_addr_q  <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tag_vld_q   <= '0;
      tag_last_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ram_addr_q  <= ram_addr_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tag_vld_q   <= tag_vld_d;
      tag_last_q  <= tag_last_d;
    end
  end

  reader_skid_fifo #(
    .Depth(FIFO_DEPTH),
    .Width(WIDTH + 1)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (tag_vld_q[RD_LATENCY]),
    .data_i ({tag_last_q[RD_LATENCY], ram_data_out}),
    .pop_i  (pop),
    .data_o (fifo_head),
    .count_o(fifo_count),
    .empty_o(fifo_empty)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wr_en   = 1'b0;
  assign ram_data_in = '0;
  assign m_valid     = !fifo_empty;
  assign m_data      = fifo_empty ? '0 : fifo_head[WIDTH-1:0];
  assign m_last      = !fifo_empty && fifo_head[WIDTH];

`ifdef READER_CHECKSUM_EN
  logic [WIDTH-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == IDLE && start) csum_d = '0;
    else if (pop) csum_d = csum_q ^ m_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_dpram_burst_reader.sv
// Scoreboard bench: reader on port A of a behavioural dual-port RAM, port B preloads.
module tb_dpram_burst_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] base_addr;
  logic [6:0] length;
  logic       busy, done;
  logic [5:0] ram_addr;
  logic       ram_wr_en;
  logic [7:0] ram_data_in, ram_data_out;
  logic [7:0] m_data;
  logic       m_valid, m_ready, m_last;
`ifdef READER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  logic       b_we;
  logic [5:0] b_addr;
  logic [7:0] b_din;
  logic [7:0] ram [64];

  always #5 clk = ~clk;

  // Dual-port RAM, both ports on clk, one-cycle registered read on port A.
  always @(posedge clk) begin
    if (b_we) ram[b_addr] <= b_din;
    if (ram_wr_en) ram[ram_addr] <= ram_data_in;
    ram_data_out <= ram[ram_addr];
  end

  dpram_burst_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .ram_addr    (ram_addr),
    .ram_wr_en   (ram_wr_en),
    .ram_data_in (ram_data_in),
    .ram_data_out(ram_data_out),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last)
`ifdef READER_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [8:0] sb[$];
  int         pop_cycles[$];
  logic [5:0] addr_log[$];
  int         cyc_cnt = 0;
  int         pop_cnt = 0;
  int         done_cnt = 0;
  bit         prev_stall = 0;
  bit         exp_done = 0;
  bit         log_addr = 0;
  logic [8:0] held;
  logic [5:0] last_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted transfer.
  always @(negedge clk) begin
    cyc_cnt++;
    if (rst) begin
      prev_stall = 0;
      exp_done   = 0;
    end else begin
      if (exp_done) begin
        chk("done_after_last", 32'(done), 1);
        chk("busy_low_after_last", 32'(busy), 0);
        exp_done = 0;
      end
      if (done) done_cnt++;
      if (prev_stall) begin
        chk("stall_valid_held", 32'(m_valid), 1);
        chk("stall_word_held", 32'({m_last, m_data}), 32'(held));
      end
      if (busy) chk("fifo_within_depth", 32'(dut.u_fifo.count_o <= 3), 1);
      if (m_valid && m_ready) begin
        logic [8:0] e;
        pop_cnt++;
        pop_cycles.push_back(cyc_cnt);
        chk("word_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("stream_word", 32'({m_last, m_data}), 32'(e));
          if (e[8]) exp_done = 1;
        end
      end
      prev_stall = m_valid && !m_ready;
      held       = {m_last, m_data};
      if (log_addr && ram_addr != last_addr) begin
        addr_log.push_back(ram_addr);
        last_addr = ram_addr;
      end
    end
  end

  task automatic preload(input logic [5:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    b_we = 1'b1; b_addr = a; b_din = d;
    @(posedge clk); #1;
    b_we = 1'b0;
  endtask

  task automatic expect_words(input logic [5:0] b, input int n);
    for (int i = 0; i < n; i++) sb.push_back({(i == n - 1), 2'b00, 6'(b + 6'(i))});
  endtask

  task automatic launch(input logic [5:0] b, input logic [6:0] l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = l;
    @(posedge clk); #1;
    start = 1'b0; base_addr = ~b; length = 7'd5;
  endtask

  task automatic run_until_idle(input bit bp, input string name);
    int cyc = 0;
    do begin
      @(posedge clk); #1;
      if (bp) m_ready = (cyc % 3 == 0);
      cyc++;
    end while ((busy || sb.size() != 0) && cyc < 600);
    m_ready = 1'b1;
    if (cyc >= 600) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: busy=%0b pending=%0d, required idle", name, busy, sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    int d0, p0, n;
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;
    b_we = 1'b0; b_addr = '0; b_din = '0;
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_valid", 32'(m_valid), 0);
    chk("reset_last", 32'(m_last), 0);
    chk("reset_ram_addr", 32'(ram_addr), 0);
    chk("reset_m_data", 32'(m_data), 0);
    chk("ram_wr_en_zero", 32'(ram_wr_en), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 64; i++) preload(6'(i), 8'(i));

    // Wrap across the top of the address space.
    d0 = done_cnt;
    last_addr = ram_addr;
    log_addr = 1;
    sb.push_back(9'h03E); sb.push_back(9'h03F); sb.push_back(9'h000); sb.push_back(9'h101);
    launch(6'h3E, 7'd4);
    run_until_idle(0, "wrap");
    log_addr = 0;
    chk("wrap_addr_count", 32'(addr_log.size()), 4);
    if (addr_log.size() == 4) begin
      chk("wrap_addr0", 32'(addr_log[0]), 32'h3E);
      chk("wrap_addr1", 32'(addr_log[1]), 32'h3F);
      chk("wrap_addr2", 32'(addr_log[2]), 32'h00);
      chk("wrap_addr3", 32'(addr_log[3]), 32'h01);
    end
    chk("wrap_done_once", 32'(done_cnt), 32'(d0 + 1));

    // Back-pressure: ready one cycle on, two off.
    d0 = done_cnt; p0 = pop_cnt;
    expect_words(6'h10, 8);
    launch(6'h10, 7'd8);
    run_until_idle(1, "backpressure");
    chk("bp_word_count", 32'(pop_cnt - p0), 8);
    chk("bp_done_once", 32'(done_cnt), 32'(d0 + 1));

    // Zero length: done pulse, no data.
    d0 = done_cnt; p0 = pop_cnt;
    launch(6'h07, 7'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("len0_valid", 32'(m_valid), 0);
    chk("len0_busy", 32'(busy), 0);
    chk("len0_done_once", 32'(done_cnt), 32'(d0 + 1));
    chk("len0_no_words", 32'(pop_cnt - p0), 0);

    // Full-size burst touches every address once.
    d0 = done_cnt; p0 = pop_cnt;
    expect_words(6'h05, 64);
    launch(6'h05, 7'd64);
    run_until_idle(0, "len64");
    chk("len64_word_count", 32'(pop_cnt - p0), 64);
    chk("len64_done_once", 32'(done_cnt), 32'(d0 + 1));

    // Start while busy is ignored.
    d0 = done_cnt; p0 = pop_cnt;
    expect_words(6'h20, 4);
    launch(6'h20, 7'd4);
    start = 1'b1; base_addr = 6'h00; length = 7'd2;
    @(posedge clk); #1;
    start = 1'b0;
    run_until_idle(0, "start_busy");
    chk("busy_start_words", 32'(pop_cnt - p0), 4);
    chk("busy_start_done_once", 32'(done_cnt), 32'(d0 + 1));

    // Reset mid-burst after two words.
    d0 = done_cnt; p0 = pop_cnt;
    expect_words(6'h30, 8);
    launch(6'h30, 7'd8);
    n = 0;
    while (pop_cnt - p0 < 2 && n < 50) begin @(negedge clk); n++; end
    chk("reset_test_two_words", 32'(pop_cnt - p0 >= 2), 1);
    #1 rst = 1'b1;
    #1;
    chk("midreset_valid", 32'(m_valid), 0);
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_done", 32'(done), 0);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_no_done", 32'(done_cnt), 32'(d0));
    expect_words(6'h08, 3);
    launch(6'h08, 7'd3);
    run_until_idle(0, "after_reset");
    chk("after_reset_done", 32'(done_cnt), 32'(d0 + 1));

    // Directed data, full rate: words on consecutive cycles.
    preload(6'h28, 8'hB5); preload(6'h29, 8'h6F); preload(6'h2A, 8'h11);
    d0 = done_cnt;
    pop_cycles.delete();
    sb.push_back(9'h0B5); sb.push_back(9'h06F); sb.push_back(9'h111);
    launch(6'h28, 7'd3);
    run_until_idle(0, "basic");
    chk("basic_pop_count", 32'(pop_cycles.size()), 3);
    if (pop_cycles.size() == 3) begin
      chk("basic_consecutive1", 32'(pop_cycles[1] - pop_cycles[0]), 1);
      chk("basic_consecutive2", 32'(pop_cycles[2] - pop_cycles[1]), 1);
    end
    chk("basic_done_once", 32'(done_cnt), 32'(d0 + 1));
`ifdef READER_CHECKSUM_EN
    chk("checksum_after_done", 32'(checksum), 32'hCB);
    sb.push_back(9'h0B5); sb.push_back(9'h06F); sb.push_back(9'h111);
    launch(6'h28, 7'd3);
    chk("checksum_cleared", 32'(checksum), 32'h00);
    run_until_idle(0, "checksum_rerun");
    chk("checksum_rerun", 32'(checksum), 32'hCB);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
